fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/cqu_mips_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 71 +++++++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cqu_mips_pkg.sv
// Shared cqu_mips definitions: reset PC default, fetch FSM encoding and the
// fetch-buffer entry layout.
package cqu_mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched instructions: head is the presented entry,
// tail is the skid slot. Flush empties it and takes priority over push/pop.
module fetch_skid_buf
  import cqu_mips_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, do_pop})
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = push_data_i;
          end else begin
            tail_d = push_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences single-outstanding memory requests,
// handles branch/exception redirects and feeds a 2-entry buffer to decode.
module fetch_ctrl
  import cqu_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  localparam logic [1:0] BufCap = 2'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         halt_q, halt_d;

  logic         redirect;
  logic [31:0]  redir_tgt;
  logic [1:0]   buf_count;
  fetch_entry_t buf_head;
  logic         buf_valid;
  logic         pop;
  logic         has_room;
  logic         launch;
  logic         kept_ack;
  logic         push;
  fetch_entry_t push_data;

  always_comb begin
    redirect  = exc_valid | br_valid;
    redir_tgt = exc_valid ? exc_target : br_target;
    buf_valid = (buf_count != 2'd0);
    pop       = buf_valid && !stall;
    // A slot popped this cycle counts as free for the launch decision.
    has_room  = (buf_count - {1'b0, pop}) < BufCap;
    launch    = rstn && (state_q == StIdle) && !redirect && !halt_q &&
                (pc_q[1:0] == 2'b00) && has_room;
    imem_req  = launch || (state_q != StIdle);
    imem_addr = {pc_q[31:2], 2'b00};
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    tgt_d          = tgt_q;
    halt_d         = halt_q;
    kept_ack       = 1'b0;
    push           = 1'b0;
    push_data.pc   = pc_q;
    push_data.inst = imem_rdata;
    push_data.adel = 1'b0;
    if (redirect) begin
      halt_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end else if (launch) begin
          if (imem_ack) begin
            kept_ack = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else if (!halt_q && (pc_q[1:0] != 2'b00) && has_room) begin
          // Misaligned target: present an AdEL entry instead of fetching, then park.
          push           = 1'b1;
          push_data.inst = '0;
          push_data.adel = 1'b1;
          halt_d         = 1'b1;
        end
      end
      StWait: begin
        if (redirect) begin
          if (imem_ack) begin
            state_d = StIdle;
            pc_d    = redir_tgt;
          end else begin
            state_d = StDrop;
            tgt_d   = redir_tgt;
          end
        end else if (imem_ack) begin
          kept_ack = 1'b1;
          state_d  = StIdle;
        end
      end
      StDrop: begin
        if (imem_ack) begin
          state_d = StIdle;
          pc_d    = redirect ? redir_tgt : tgt_q;
        end else if (redirect) begin
          tgt_d = redir_tgt;
        end
      end
      default: state_d = StIdle;
    endcase
    if (kept_ack) begin
      push = 1'b1;
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      halt_q  <= halt_d;
    end
  end

  fetch_skid_buf u_buf (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (buf_count),
    .head_o      (buf_head)
  );

  always_comb begin
    if_valid = buf_valid;
    if_pc    = buf_valid ? buf_head.pc   : 32'd0;
    if_inst  = buf_valid ? buf_head.inst : 32'd0;
    if_adel  = buf_valid && buf_head.adel;
  end

endmodule
